// File: rtl/nn_epoch_sequencer_if.sv
// Bus bundle between the epoch sequencer and the network phase controller.
// The sequencer takes the master view; the controller side (or a bench) takes slave.
interface nn_epoch_sequencer_if #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned EPOCH_W = 8
);
    logic               start;
    logic               abort;
    logic               S_Train;
    logic               S_Error;
    logic               err_flag;
    logic               TR;
    logic               VL;
    logic [ADDR_W-1:0]  sample_addr;
    logic [EPOCH_W-1:0] epoch;
    logic [ADDR_W-1:0]  err_count;
    logic [ADDR_W-1:0]  epoch_err;
    logic               epoch_done;
    logic               busy;
    logic               done;
    logic               converged;
    logic               timeout_err;

    modport master (
        input  start, abort, S_Train, S_Error, err_flag,
        output TR, VL, sample_addr, epoch, err_count, epoch_err, epoch_done,
               busy, done, converged, timeout_err
    );

    modport slave (
        output start, abort, S_Train, S_Error, err_flag,
        input  TR, VL, sample_addr, epoch, err_count, epoch_err, epoch_done,
               busy, done, converged, timeout_err
    );
endinterface

// File: rtl/nn_epoch_sequencer.sv
// Epoch sequencer: walks the training then validation samples, launches TR/VL
// pulses, tallies validation errors per epoch and stops on convergence, epoch
// limit, abort or watchdog timeout. All outputs are registered.
module nn_epoch_sequencer #(
    parameter int unsigned N_TRAIN = 16,
    parameter int unsigned N_VALID = 4,
    parameter int unsigned N_EPOCH = 8,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned EPOCH_W = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst,
    nn_epoch_sequencer_if.master bus
);
    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0]  LAST_T   = ADDR_W'(N_TRAIN - 1);
    localparam logic [ADDR_W-1:0]  FIRST_V  = ADDR_W'(N_TRAIN);
    localparam logic [ADDR_W-1:0]  LAST_V   = ADDR_W'(N_TRAIN + N_VALID - 1);
    localparam logic [EPOCH_W-1:0] LAST_E   = EPOCH_W'(N_EPOCH - 1);
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTrainIssue,
        StTrainWait,
        StValidIssue,
        StValidWait,
        StEpochEnd,
        StDone,
        StFault
    } state_t;

    state_t            state;
    logic [WD_W-1:0]   watchdog;
    logic [ADDR_W-1:0] err_inc;

    // Error count plus the current misclassification flag, saturating at all-ones.
    always_comb begin
        err_inc = bus.err_count;
        if (bus.err_flag && (bus.err_count != '1)) begin
            err_inc = bus.err_count + ADDR_W'(1);
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            watchdog        <= '0;
            bus.TR          <= 1'b0;
            bus.VL          <= 1'b0;
            bus.sample_addr <= '0;
            bus.epoch       <= '0;
            bus.err_count   <= '0;
            bus.epoch_err   <= '0;
            bus.epoch_done  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.converged   <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.TR         <= 1'b0;
            bus.VL         <= 1'b0;
            bus.epoch_done <= 1'b0;
            bus.done       <= 1'b0;
            // busy is high in exactly the abortable states; abort beats completions
            if (bus.abort && bus.busy) begin
                bus.busy <= 1'b0;
                state    <= StIdle;
            end else begin
                unique case (state)
                    StIdle, StFault: begin
                        if (bus.start) begin
                            bus.sample_addr <= '0;
                            bus.epoch       <= '0;
                            bus.err_count   <= '0;
                            bus.converged   <= 1'b0;
                            bus.timeout_err <= 1'b0;
                            bus.busy        <= 1'b1;
                            bus.TR          <= 1'b1;
                            state           <= StTrainIssue;
                        end
                    end
                    StTrainIssue: begin
                        watchdog <= '0;
                        state    <= StTrainWait;
                    end
                    StTrainWait: begin
                        if (bus.S_Train) begin
                            if (bus.sample_addr == LAST_T) begin
                                bus.sample_addr <= FIRST_V;
                                bus.VL          <= 1'b1;
                                state           <= StValidIssue;
                            end else begin
                                bus.sample_addr <= bus.sample_addr + ADDR_W'(1);
                                bus.TR          <= 1'b1;
                                state           <= StTrainIssue;
                            end
                        end else if (watchdog == WD_LIMIT) begin
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= StFault;
                        end else begin
                            watchdog <= watchdog + WD_W'(1);
                        end
                    end
                    StValidIssue: begin
                        watchdog <= '0;
                        state    <= StValidWait;
                    end
                    StValidWait: begin
                        if (bus.S_Error) begin
                            bus.err_count <= err_inc;
                            if (bus.sample_addr == LAST_V) begin
                                bus.epoch_err  <= err_inc;
                                bus.epoch_done <= 1'b1;
                                state          <= StEpochEnd;
                            end else begin
                                bus.sample_addr <= bus.sample_addr + ADDR_W'(1);
                                bus.VL          <= 1'b1;
                                state           <= StValidIssue;
                            end
                        end else if (watchdog == WD_LIMIT) begin
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= StFault;
                        end else begin
                            watchdog <= watchdog + WD_W'(1);
                        end
                    end
                    StEpochEnd: begin
                        if ((bus.err_count == '0) || (bus.epoch == LAST_E)) begin
                            bus.converged <= (bus.err_count == '0);
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= StDone;
                        end else begin
                            bus.epoch       <= bus.epoch + EPOCH_W'(1);
                            bus.sample_addr <= '0;
                            bus.err_count   <= '0;
                            bus.TR          <= 1'b1;
                            state           <= StTrainIssue;
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nn_epoch_sequencer.sv
// Bench for nn_epoch_sequencer: randomized runs checked by a scoreboard of
// expected TR/VL/epoch_done/done events, plus directed timeout, abort and reset cases.
module tb_nn_epoch_sequencer;
    localparam int NT = 2;
    localparam int NV = 2;
    localparam int NE = 3;
    localparam int TO = 64;
    localparam int AW = 6;
    localparam int EW = 8;

    localparam int EV_TR   = 0;
    localparam int EV_VL   = 1;
    localparam int EV_ED   = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int addr;
        int ep;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nn_epoch_sequencer_if #(.ADDR_W(AW), .EPOCH_W(EW)) bus ();

    nn_epoch_sequencer #(
        .N_TRAIN(NT), .N_VALID(NV), .N_EPOCH(NE),
        .ADDR_W(AW), .EPOCH_W(EW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Manual and responder drives are merged so each bus input has one driver.
    logic man_train = 1'b0, man_error = 1'b0, man_flag = 1'b0;
    logic rsp_train = 1'b0, rsp_error = 1'b0, rsp_flag = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    assign bus.S_Train  = man_train | rsp_train;
    assign bus.S_Error  = man_error | rsp_error;
    assign bus.err_flag = man_flag | rsp_flag;
    assign bus.start    = start;
    assign bus.abort    = abort;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  tr_cnt = 0, vl_cnt = 0, ed_cnt = 0, done_cnt = 0;
    bit  sb_on = 1'b0;
    bit  resp_on = 1'b0;
    ev_t exp_q[$];
    bit  flag_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.TR, bus.VL, bus.sample_addr, bus.epoch, bus.err_count, bus.epoch_err,
                    bus.epoch_done, bus.busy, bus.done, bus.converged, bus.timeout_err});
    endfunction

    // Monitor: counts launch/completion pulses and checks them against the scoreboard.
    int  mk;
    ev_t mev;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.TR) tr_cnt++;
            if (bus.VL) vl_cnt++;
            if (bus.epoch_done) ed_cnt++;
            if (bus.done) done_cnt++;
            if (sb_on && (bus.TR || bus.VL || bus.epoch_done || bus.done)) begin
                mk = bus.TR ? EV_TR : bus.VL ? EV_VL : bus.epoch_done ? EV_ED : EV_DONE;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: got event kind %0d expected none", mk);
                end else begin
                    mev = exp_q.pop_front();
                    check("sb_kind", 64'(mk), 64'(mev.kind));
                    check("sb_epoch", 64'(bus.epoch), 64'(mev.ep));
                    if (mev.kind == EV_ED) begin
                        check("sb_epoch_err", 64'(bus.epoch_err), 64'(mev.val));
                    end else if (mev.kind == EV_DONE) begin
                        check("sb_converged", 64'(bus.converged), 64'(mev.val));
                        check("sb_done_addr", 64'(bus.sample_addr), 64'(mev.addr));
                    end else begin
                        check("sb_addr", 64'(bus.sample_addr), 64'(mev.addr));
                    end
                end
            end
        end
    end

    // Responder: plays the phase controller, with random latency and stray wrong-kind pulses.
    bit rsp_v;
    int rsp_d;
    initial forever begin
        @(negedge clk);
        while (resp_on && (bus.TR || bus.VL)) begin
            rsp_v = bus.VL;
            rsp_d = $urandom_range(0, 8);
            @(negedge clk);
            repeat (rsp_d) begin
                if (rsp_v) begin
                    rsp_train = ($urandom_range(0, 3) == 0);
                end else begin
                    rsp_error = ($urandom_range(0, 3) == 0);
                    rsp_flag  = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
            if (rsp_v) begin
                rsp_train = 1'b0;
                rsp_error = 1'b1;
                rsp_flag  = (flag_q.size() != 0) ? flag_q.pop_front() : 1'b0;
            end else begin
                rsp_error = 1'b0;
                rsp_flag  = 1'b0;
                rsp_train = 1'b1;
            end
            @(negedge clk);
            rsp_train = 1'b0;
            rsp_error = 1'b0;
            rsp_flag  = 1'b0;
        end
    end

    // One full run; the expected event stream comes from the epoch/convergence rules.
    task automatic run_random(input int pct);
        int  ntr, nvl, e_last, errs, tr0, vl0, d0, c;
        bit  conv, f;
        exp_q.delete();
        flag_q.delete();
        ntr = 0; nvl = 0; e_last = 0; conv = 1'b0;
        for (int e = 0; e < NE; e++) begin
            errs = 0;
            for (int a = 0; a < NT; a++) begin
                exp_q.push_back('{EV_TR, a, e, 0});
                ntr++;
            end
            for (int v = 0; v < NV; v++) begin
                f = ($urandom_range(0, 99) < pct);
                flag_q.push_back(f);
                errs += int'(f);
                exp_q.push_back('{EV_VL, NT + v, e, 0});
                nvl++;
            end
            exp_q.push_back('{EV_ED, 0, e, errs});
            if (errs == 0 || e == NE - 1) begin
                conv   = (errs == 0);
                e_last = e;
                exp_q.push_back('{EV_DONE, NT + NV - 1, e, int'(conv)});
                break;
            end
        end
        tr0 = tr_cnt; vl0 = vl_cnt; d0 = done_cnt;
        sb_on = 1'b1;
        resp_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        // start held while busy must not restart the run
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start = 1'b0;
        c = 0;
        while (done_cnt == d0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("run_done_seen", 64'(done_cnt - d0), 64'd1);
        repeat (3) @(negedge clk);
        resp_on = 1'b0;
        sb_on = 1'b0;
        check("run_queue_empty", 64'(exp_q.size()), 64'd0);
        check("run_tr_total", 64'(tr_cnt - tr0), 64'(ntr));
        check("run_vl_total", 64'(vl_cnt - vl0), 64'(nvl));
        check("run_converged", 64'(bus.converged), 64'(conv));
        check("run_epoch", 64'(bus.epoch), 64'(e_last));
        check("run_busy_low", 64'(bus.busy), 64'd0);
        if (bus.busy) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    int tr_s, vl_s, d_s, ed_s, cyc;

    initial begin
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 64'd0);

        run_random(0);
        run_random(100);

        // abort together with S_Train at addr 1
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ab_tr_addr0", 64'({bus.TR, bus.sample_addr}), 64'({1'b1, 6'd0}));
        @(negedge clk);
        man_train = 1'b1;
        @(negedge clk);
        man_train = 1'b0;
        check("ab_tr_addr1", 64'({bus.TR, bus.sample_addr}), 64'({1'b1, 6'd1}));
        @(negedge clk);
        man_train = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        man_train = 1'b0;
        abort = 1'b0;
        tr_s = tr_cnt; vl_s = vl_cnt; d_s = done_cnt; ed_s = ed_cnt;
        check("ab_busy", 64'(bus.busy), 64'd0);
        check("ab_addr_hold", 64'(bus.sample_addr), 64'd1);
        // stray completions while idle
        man_train = 1'b1;
        man_error = 1'b1;
        man_flag = 1'b1;
        @(negedge clk);
        man_train = 1'b0;
        man_error = 1'b0;
        man_flag = 1'b0;
        repeat (10) @(negedge clk);
        check("ab_no_pulses", 64'({tr_cnt - tr_s, vl_cnt - vl_s, done_cnt - d_s, ed_cnt - ed_s}),
              64'd0);
        check("ab_idle_state", 64'({bus.sample_addr, bus.err_count, bus.busy}),
              64'({6'd1, 6'd0, 1'b0}));

        // watchdog timeout in T_WAIT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_first_tr", 64'(bus.TR), 64'd1);
        cyc = 0;
        while (!bus.timeout_err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", 64'(cyc), 64'd65);
        check("to_busy", 64'(bus.busy), 64'd0);
        tr_s = tr_cnt;
        repeat (10) @(negedge clk);
        check("to_no_tr", 64'(tr_cnt - tr_s), 64'd0);
        check("to_err_level", 64'(bus.timeout_err), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_restart", 64'({bus.TR, bus.sample_addr, bus.timeout_err, bus.busy}),
              64'({1'b1, 6'd0, 1'b0, 1'b1}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("to_abort_idle", 64'(bus.busy), 64'd0);

        // reset in the middle of V_WAIT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        man_train = 1'b1;
        @(negedge clk);
        man_train = 1'b0;
        @(negedge clk);
        man_train = 1'b1;
        @(negedge clk);
        man_train = 1'b0;
        check("rs_vl_addr2", 64'({bus.VL, bus.sample_addr}), 64'({1'b1, 6'd2}));
        @(negedge clk);
        man_error = 1'b1;
        man_flag = 1'b1;
        @(negedge clk);
        man_error = 1'b0;
        man_flag = 1'b0;
        check("rs_err_count", 64'({bus.VL, bus.sample_addr, bus.err_count}),
              64'({1'b1, 6'd3, 6'd1}));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rs_async_clear", all_outputs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_start_after", 64'({bus.TR, bus.busy, bus.sample_addr}),
              64'({1'b1, 1'b1, 6'd0}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        for (int r = 0; r < 10; r++) begin
            run_random((r % 3 == 0) ? 20 : (r % 3 == 1) ? 50 : 80);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "bench time limit");
    end
endmodule
